// File: rtl/y86_pkg.sv
// y86_pkg: Y86-64 icode constants, memory size and instruction-length helper shared by encoder and fetch.
package y86_pkg;
    localparam logic [3:0] HALT   = 4'h0;
    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] CMOVXX = 4'h2;
    localparam logic [3:0] IRMOVQ = 4'h3;
    localparam logic [3:0] RMMOVQ = 4'h4;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] OPQ    = 4'h6;
    localparam logic [3:0] JXX    = 4'h7;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'hA;
    localparam logic [3:0] POPQ   = 4'hB;
    localparam logic [3:0] RNONE  = 4'hF;
    localparam int IMEM_BYTES_DEFAULT = 1024;

    // Zero marks an icode the fetch stage would treat as invalid.
    function automatic logic [3:0] instr_len(input logic [3:0] icode);
        case (icode)
            HALT, NOP, RET:             instr_len = 4'd1;
            CMOVXX, OPQ, PUSHQ, POPQ:   instr_len = 4'd2;
            JXX, CALL:                  instr_len = 4'd9;
            IRMOVQ, RMMOVQ, MRMOVQ:     instr_len = 4'd10;
            default:                    instr_len = 4'd0;
        endcase
    endfunction
endpackage

// File: rtl/y86_instr_encoder.sv
// y86_instr_encoder: serialises decoded Y86-64 instructions into bytes written to instruction memory.
module y86_instr_encoder
    import y86_pkg::*;
#(
    parameter int IMEM_BYTES = IMEM_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    input  logic [63:0] load_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [63:0] valC,
    output logic        wr_en,
    output logic [9:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        done,
    output logic [3:0]  instr_len,
    output logic [63:0] next_pc,
    output logic        instr_invalid,
    output logic        imem_error
);
    typedef enum logic {IDLE, EMIT} state_t;

    state_t      state, state_n;
    logic [63:0] wptr;
    logic [79:0] sreg, frame, src;
    logic [3:0]  cnt, len, len_in, rem;
    logic        accept, bad, overrun, start, emit;

    assign in_ready = (state == IDLE) && !load_valid && !rst;

    // Byte 0 leaves on the accepting edge, so cnt counts bytes still queued behind the one on the port.
    always_comb begin
        accept  = in_valid && in_ready;
        len_in  = y86_pkg::instr_len(icode);
        bad     = len_in == 4'd0;
        overrun = ({1'b0, wptr} + 65'(len_in)) > 65'(IMEM_BYTES);
        start   = accept && !bad && !overrun;
        emit    = start || (state == EMIT && cnt != 4'd0);
        frame   = len_in == 4'd10 ? {icode, ifun, rA, rB, valC}
                : len_in == 4'd9  ? {icode, ifun, valC, 8'h00}
                : len_in == 4'd2  ? {icode, ifun, rA, rB, 64'h0}
                :                   {icode, ifun, 72'h0};
        src     = start ? frame : sreg;
        rem     = start ? len_in - 4'd1 : cnt - 4'd1;
        state_n = start ? EMIT : (state == EMIT && cnt == 4'd0) ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr          <= '0;
            sreg          <= '0;
            cnt           <= '0;
            len           <= '0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            done          <= 1'b0;
            instr_len     <= '0;
            next_pc       <= '0;
            instr_invalid <= 1'b0;
            imem_error    <= 1'b0;
        end else begin
            wr_en         <= 1'b0;
            done          <= 1'b0;
            instr_invalid <= accept && bad;
            imem_error    <= accept && !bad && overrun;
            if (state == IDLE && load_valid) wptr <= load_addr;
            if (start) len <= len_in;
            if (emit) begin
                wr_en   <= 1'b1;
                wr_addr <= wptr[9:0];
                wr_data <= src[79:72];
                sreg    <= src << 8;
                cnt     <= rem;
                wptr    <= wptr + 64'd1;
                if (rem == 4'd0) begin
                    done      <= 1'b1;
                    instr_len <= start ? len_in : len;
                    next_pc   <= wptr + 64'd1;
                end
            end
        end
    end
endmodule

// File: doc/y86_instr_encoder.md
# y86_instr_encoder

Y86-64 instruction encoder and instruction-memory writer: the producer side of the byte-serial instruction format the fetch stage decodes. It accepts one decoded instruction (icode, ifun, rA, rB, valC) per handshake and serialises it into 1, 2, 9 or 10 bytes. It writes those bytes one per cycle into the 1024-byte instruction memory at an auto-incrementing write pointer. Testbenches and the program loader use it to build programs from fields instead of hand-written bytes.

## Interface
- IMEM_BYTES, 1024: instruction memory size in bytes.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- load_valid  in  1  request to set the write pointer.
- load_addr  in  64  new write-pointer value.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  encoder can accept an instruction.
- icode, ifun, rA, rB  in  4 each  instruction fields.
- valC  in  64  constant or destination.
- wr_en  out  1  byte write strobe to instruction memory.
- wr_addr  out  10  byte address.
- wr_data  out  8  byte value.
- done  out  1  one-cycle pulse on the last byte of an instruction.
- instr_len  out  4  length of the instruction just completed; valid with done.
- next_pc  out  64  write pointer after the instruction; valid with done.
- instr_invalid  out  1  one-cycle pulse: an icode greater than 0xB was rejected.
- imem_error  out  1  one-cycle pulse: the instruction would overrun memory and was rejected.

## Operation
- States: IDLE, EMIT.
- in_ready = (state==IDLE) && !load_valid && !rst.
- In IDLE, load_valid has priority: wptr <= load_addr. It is ignored in EMIT.
- Acceptance happens when in_valid && in_ready. Checks run in order:
  - icode > 0xB: pulse instr_invalid, stay in IDLE, no writes.
  - wptr + len > IMEM_BYTES (64-bit compare): pulse imem_error, stay in IDLE, wptr unchanged.
  - Otherwise: latch the bytes into an 80-bit shift register, set the remaining count to len, go to EMIT.
- Lengths:
  - halt(0), nop(1), ret(9): 1 byte.
  - cmovXX(2), OPq(6), pushq(A), popq(B): 2 bytes.
  - jXX(7), call(8): 9 bytes.
  - irmovq(3), rmmovq(4), mrmovq(5): 10 bytes.
- Byte layout:
  - byte0 = {icode, ifun}.
  - For 2- and 10-byte formats, byte1 = {rA, rB}. rA and rB are passed through unchanged; the caller supplies 0xF where a register is unused.
  - valC is big-endian (MSB first): bytes 2..9 for 10-byte formats, bytes 1..8 for jXX and call.
- ifun is not checked.
- EMIT, each cycle:
  - wr_en=1, wr_addr=wptr[9:0], wr_data=top byte.
  - Shift the register, increment wptr, decrement the count.
  - On the last byte, also assert done, instr_len=len and next_pc=wptr+1, then return to IDLE.

## Timing
- All outputs except in_ready are registered.
- Reset values: state IDLE, wptr 0, wr_en 0, wr_addr 0, wr_data 0, done 0, instr_len 0, next_pc 0, instr_invalid 0, imem_error 0. in_ready is 0 while rst is high.
- For acceptance at edge N:
  - Byte k (k = 0..len-1) is on the write port in the cycle after edge N+k.
  - done coincides with byte len-1.
  - in_ready returns high the cycle after the last byte.
- Throughput is len+1 cycles per instruction.
- Error pulses are visible in the cycle after the rejecting edge. in_ready stays high through a rejection.
- A 1-byte instruction at wptr 1023 is legal; afterwards next_pc = 1024 and every later accept raises imem_error.
- rst during EMIT:
  - wr_en is 0 from the next cycle; done never fires.
  - Bytes already written stay in memory.
  - wptr returns to 0.
- load_valid and in_valid together in IDLE: the load wins and the instruction waits. in_valid must stay asserted until accepted.

## Structure
- Shared package y86_pkg holds:
  - Icode constants: HALT, NOP, CMOVXX, IRMOVQ, RMMOVQ, MRMOVQ, OPQ, JXX, CALL, RET, PUSHQ, POPQ.
  - A RNONE = 0xF constant.
  - The IMEM_BYTES default.
  - A pure function instr_len(icode) returning 0 for invalid codes.
- The fetch stage should use the same package.
- No sub-module: the FSM, shift register and pointer fit in one module.

## Test plan
- Reset, then irmovq (3,0,F,2, valC=0x11): bytes 30,F2,00×7,11 at addresses 0..9 on 10 consecutive cycles; done with instr_len=10, next_pc=10.
- load_pc 32, then OPq (6,0,2,3), then nop: 60@32, 23@33, done with next_pc=34; in_ready low during both OPq bytes; then 10@34, next_pc=35.
- jXX (7,0, valC=0x20) at 0: 70 then 00×7 then 20; instr_len=9.
- icode=0xC: one instr_invalid pulse; no wr_en; wptr unchanged (a following nop writes at the old wptr).
- load_pc 1020, then irmovq: imem_error pulse, no writes. Then halt: 00@1020, next_pc=1021.
- rmmovq with rst asserted after the third byte: wr_en low the next cycle; no done. After release, in_ready=1 and a nop writes 10@0.
